hazard_stall_unit: RTL and testbench

// - Producer-side partner of the forwarding unit: decides when the pipeline must stall or flush so forwarded data is valid.
// - Keeps its own shadow copy of in-flight destinations (EX, MEM, WB) and compares them with the ID-stage sources.
// - Drives PC/IF_ID write enables, the ID_EX bubble and branch flushes, and counts stall cycles.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_scoreboard.sv | 29 ++
 rtl/hazard_stall_unit.sv | 78 +++++++
 tb/tb_hazard_stall_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, constants and the RAW match helper for the hazard stall unit.
package hazard_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;
  typedef struct packed {
    logic             vld;
    logic             regwrite;
    logic             memread;
    logic [REG_W-1:0] rd;
  } stage_t;
  typedef enum logic {HZ_RUN, HZ_STALL} hz_state_t;
  function automatic logic raw_match(stage_t s, logic [REG_W-1:0] rs, logic [REG_W-1:0] rt,
                                     logic uses_rt);
    return s.vld & s.regwrite & (s.rd != ZERO_REG) & ((s.rd == rs) | (uses_rt & (s.rd == rt)));
  endfunction
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shadow EX/MEM/WB destination stages, cleared by bubbles and branch flushes.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  stage_t id_i,
  input  logic   bubble_i,
  input  logic   flush_i,
  output stage_t ex_o,
  output stage_t mem_o,
  output stage_t wb_o
);
  stage_t ex_q, mem_q, wb_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= (bubble_i | flush_i) ? '0 : id_i;
      mem_q <= flush_i ? '0 : ex_q;
      wb_q  <= mem_q;
    end
  end
  assign ex_o  = ex_q;
  assign mem_o = mem_q;
  assign wb_o  = wb_q;
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: stall/flush control with stall and flush counters.
// FORWARDING_EN selects the load-use-only hazard rule; otherwise any EX/MEM RAW match stalls.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] IF_ID_RegisterRs_i,
  input  logic [REG_W-1:0] IF_ID_RegisterRt_i,
  input  logic             ID_UsesRt_i,
  input  logic             ID_RegWrite_i,
  input  logic             ID_MemRead_i,
  input  logic [REG_W-1:0] ID_RegisterRd_i,
  input  logic             Branch_taken_i,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             ID_EX_Bubble_o,
  output logic             IF_ID_Flush_o,
  output logic             EX_MEM_Flush_o,
  output logic [CNT_W-1:0] Stall_cnt_o,
  output logic [CNT_W-1:0] Flush_cnt_o
);
  stage_t id_s, ex_s, mem_s, wb_s;
  logic hazard, flush, stall;
  hz_state_t state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  assign id_s = '{vld: 1'b1, regwrite: ID_RegWrite_i, memread: ID_MemRead_i, rd: ID_RegisterRd_i};
  hazard_scoreboard u_sb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .id_i    (id_s),
    .bubble_i(stall),
    .flush_i (flush),
    .ex_o    (ex_s),
    .mem_o   (mem_s),
    .wb_o    (wb_s)
  );
`ifdef FORWARDING_EN
  assign hazard = ex_s.memread &
                  raw_match(ex_s, IF_ID_RegisterRs_i, IF_ID_RegisterRt_i, ID_UsesRt_i);
`else
  assign hazard = raw_match(ex_s, IF_ID_RegisterRs_i, IF_ID_RegisterRt_i, ID_UsesRt_i) |
                  raw_match(mem_s, IF_ID_RegisterRs_i, IF_ID_RegisterRt_i, ID_UsesRt_i);
`endif
  // gating with reset keeps every output at its reset value while rst_i is low
  assign flush          = Branch_taken_i & rst_i;
  assign stall          = hazard & ~flush;
  assign PC_Write_o     = ~stall;
  assign IF_ID_Write_o  = ~stall;
  assign ID_EX_Bubble_o = stall;
  assign IF_ID_Flush_o  = flush;
  assign EX_MEM_Flush_o = flush;
  assign Stall_cnt_o    = stall_cnt_q;
  assign Flush_cnt_o    = flush_cnt_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_RUN:   state_d = stall ? HZ_STALL : HZ_RUN;
      HZ_STALL: state_d = stall ? HZ_STALL : HZ_RUN;
      default:  state_d = HZ_RUN;
    endcase
    stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= HZ_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed and random checks against an in-flight instruction queue model.
module tb_hazard_stall_unit;
  localparam int CNT_W = 16;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [4:0] rs_i = '0, rt_i = '0, rd_i = '0;
  logic ut_i = 1'b0, wr_i = 1'b0, ld_i = 1'b0, br_i = 1'b0;
  logic pc_o, ifid_o, bub_o, iff_o, emf_o;
  logic [CNT_W-1:0] sc_o, fc_o;

  hazard_stall_unit #(.CNT_W(CNT_W)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .IF_ID_RegisterRs_i(rs_i),
    .IF_ID_RegisterRt_i(rt_i),
    .ID_UsesRt_i       (ut_i),
    .ID_RegWrite_i     (wr_i),
    .ID_MemRead_i      (ld_i),
    .ID_RegisterRd_i   (rd_i),
    .Branch_taken_i    (br_i),
    .PC_Write_o        (pc_o),
    .IF_ID_Write_o     (ifid_o),
    .ID_EX_Bubble_o    (bub_o),
    .IF_ID_Flush_o     (iff_o),
    .EX_MEM_Flush_o    (emf_o),
    .Stall_cnt_o       (sc_o),
    .Flush_cnt_o       (fc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {bit wr; bit ld; int rd;} ins_t;
  ins_t nop = '{0, 0, 0};
  ins_t flight[$];
  int exp_sc = 0, exp_fc = 0;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic check(string name, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit raw(ins_t p, int rs, int rt, bit ut);
    return p.wr && p.rd != 0 && (p.rd == rs || (ut && p.rd == rt));
  endfunction

  // flight[0] entered EX last cycle, flight[1] is one stage older (MEM)
  function automatic bit model_stall();
    bit hz;
`ifdef FORWARDING_EN
    hz = flight[0].ld && raw(flight[0], rs_i, rt_i, ut_i);
`else
    hz = raw(flight[0], rs_i, rt_i, ut_i) || raw(flight[1], rs_i, rt_i, ut_i);
`endif
    return hz && !br_i;
  endfunction

  bit u_st;
  ins_t u_n;
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      flight = {nop, nop};
      exp_sc = 0;
      exp_fc = 0;
    end else begin
      u_st = model_stall();
      u_n = '{wr_i, ld_i, int'(rd_i)};
      if (br_i) begin
        flight = {nop, nop};
        if (exp_fc < 65535) exp_fc++;
      end else begin
        if (u_st) begin
          u_n = nop;
          if (exp_sc < 65535) exp_sc++;
        end
        flight = {u_n, flight[0]};
      end
    end
  end

  bit m_st;
  always @(negedge clk_i) begin
    if (rst_i && chk_en) begin
      m_st = model_stall();
      check("pc_write", int'(pc_o), int'(!m_st));
      check("if_id_write", int'(ifid_o), int'(!m_st));
      check("bubble", int'(bub_o), int'(m_st));
      check("if_id_flush", int'(iff_o), int'(br_i));
      check("ex_mem_flush", int'(emf_o), int'(br_i));
      check("stall_cnt", int'(sc_o), exp_sc);
      check("flush_cnt", int'(fc_o), exp_fc);
    end
  end

  task automatic drive(int rs, int rt, bit ut, bit wr, bit ld, int rd, bit br = 0);
    rs_i = 5'(rs); rt_i = 5'(rt); ut_i = ut; wr_i = wr; ld_i = ld; rd_i = 5'(rd); br_i = br;
    @(negedge clk_i);
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    {rs_i, rt_i, rd_i, ut_i, wr_i, ld_i, br_i} = '0;
    rst_i = 1'b0;
    #2;
    check("rst_pc", int'(pc_o), 1);
    check("rst_cnt", int'(sc_o) + int'(fc_o), 0);
    #11;
    rst_i = 1'b1;
  endtask

  initial begin
    flight = {nop, nop};
    chk_en = 1;
    do_reset();
`ifdef FORWARDING_EN
    drive(0, 0, 0, 1, 1, 2); tick();
    drive(2, 4, 1, 1, 0, 3);
    check("lu_pc", int'(pc_o), 0);
    check("lu_bubble", int'(bub_o), 1);
    tick();
    drive(2, 4, 1, 1, 0, 3);
    check("lu_resume_pc", int'(pc_o), 1);
    check("lu_stall_cnt", int'(sc_o), 1);
    tick();
`else
    drive(0, 0, 0, 1, 0, 2); tick();
    drive(2, 2, 1, 1, 0, 5);
    check("nf_pc1", int'(pc_o), 0);
    tick();
    drive(2, 2, 1, 1, 0, 5);
    check("nf_pc2", int'(pc_o), 0);
    check("nf_bubble2", int'(bub_o), 1);
    tick();
    drive(2, 2, 1, 1, 0, 5);
    check("nf_resume_pc", int'(pc_o), 1);
    check("nf_stall_cnt", int'(sc_o), 2);
    tick();
`endif
    do_reset();
    drive(0, 0, 0, 1, 1, 0);
    check("zero_pc1", int'(pc_o), 1);
    tick();
    drive(0, 0, 1, 1, 0, 6);
    check("zero_pc2", int'(pc_o), 1);
    check("zero_ifid", int'(ifid_o), 1);
    tick();
    do_reset();
    drive(0, 0, 0, 1, 1, 2); tick();
    drive(2, 0, 0, 1, 0, 3, 1);
    check("fl_if_id_flush", int'(iff_o), 1);
    check("fl_ex_mem_flush", int'(emf_o), 1);
    check("fl_pc", int'(pc_o), 1);
    check("fl_bubble", int'(bub_o), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("fl_stall_cnt", int'(sc_o), 0);
    check("fl_flush_cnt", int'(fc_o), 1);
    tick();
    do_reset();
    drive(0, 0, 0, 1, 1, 2); tick();
    drive(3, 2, 0, 1, 0, 2);
    check("addi_pc", int'(pc_o), 1);
    tick();
    do_reset();
    drive(0, 0, 0, 1, 1, 2); tick();
    drive(2, 0, 0, 1, 0, 3); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 1, 7); tick();
    drive(7, 0, 0, 1, 0, 8);
    check("mid_pc_stalled", int'(pc_o), 0);
    check("mid_stall_cnt", int'(sc_o), 1);
    rst_i = 1'b0;
    #1;
    check("mid_rst_pc", int'(pc_o), 1);
    check("mid_rst_ifid", int'(ifid_o), 1);
    check("mid_rst_bubble", int'(bub_o), 0);
    check("mid_rst_flush", int'(iff_o) + int'(emf_o), 0);
    check("mid_rst_stall_cnt", int'(sc_o), 0);
    check("mid_rst_flush_cnt", int'(fc_o), 0);
    #6;
    rst_i = 1'b1;
    begin
      bit hold = 0;
      int rs = 0, rt = 0, rd = 0;
      bit ut = 0, wr = 0, ld = 0;
      for (int i = 0; i < 400; i++) begin
        if (!hold) begin
          rs = $urandom_range(0, 3); rt = $urandom_range(0, 3); rd = $urandom_range(0, 3);
          ut = 1'($urandom); wr = 1'($urandom_range(0, 3) != 0); ld = 1'($urandom);
        end
        drive(rs, rt, ut, wr, ld, rd, $urandom_range(0, 9) == 0);
        hold = model_stall();
        tick();
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
